// File: rtl/seq_muldiv_unit_pkg.sv
// Shared types and defaults for the sequential signed multiply/divide engine.
// Imported by the top level and by the step counter.
package seq_muldiv_unit_pkg;

  localparam int N_BITS = 8;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} muldiv_state_t;
  typedef enum logic {MODE_MUL, MODE_DIV} muldiv_mode_t;

endpackage

// File: rtl/seq_muldiv_unit_step_counter.sv
// Step counter for the RUN phase: clear, enable, and a terminal count that
// fires on the last of NBits steps.
module muldiv_step_counter
  import seq_muldiv_unit_pkg::*;
#(
  parameter int NBits = N_BITS,
  parameter int CntW  = $clog2(NBits) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CntW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CntW'(NBits - 1));

endmodule

// File: rtl/seq_muldiv_unit.sv
// Signed multiply/divide engine on one unsigned magnitude datapath:
// shift-add multiply, restoring divide, sign applied in a final FIX cycle.
module seq_muldiv_unit
  import seq_muldiv_unit_pkg::*;
#(
  parameter int NBits = N_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mode,
  input  logic [NBits-1:0]   op_a,
  input  logic [NBits-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*NBits-1:0] result,
  output logic               sign,
  output logic               div_zero,
  output logic               ovf
);

  localparam int CntW = $clog2(NBits) + 1;
  localparam int AccW = 2 * NBits + 1;
  localparam logic [NBits-1:0] MinMag = {1'b1, {(NBits-1){1'b0}}};

  muldiv_state_t state_q, state_d;
  muldiv_mode_t  mode_q;
  logic [NBits-1:0] a_raw_q, b_raw_q, a_mag_q, b_mag_q;
  logic             a_sign_q, b_sign_q;
  logic [AccW-1:0]  acc_q, acc_step;
  logic [2*NBits-1:0] result_q, fix_result;
  logic sign_q, div_zero_q, ovf_q, fix_sign, fix_dz, fix_ovf;
  logic accept, run_tc;
  logic [NBits-1:0] a_mag_w, b_mag_w, quo_s, rem_s;
  logic [NBits:0]   mul_upper;
  logic [NBits+1:0] trial;
  logic [AccW-1:0]  sh;

  assign accept  = start && (state_q == IDLE || state_q == DONE);
  // -(-2^(N-1)) wraps to 2^(N-1), which is exact when read as unsigned.
  assign a_mag_w = a_raw_q[NBits-1] ? -a_raw_q : a_raw_q;
  assign b_mag_w = b_raw_q[NBits-1] ? -b_raw_q : b_raw_q;

  muldiv_step_counter #(.NBits(NBits), .CntW(CntW)) u_step_counter (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (state_q == LOAD),
    .en_i  (state_q == RUN),
    .tc_o  (run_tc)
  );

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOAD;
      LOAD:    state_d = RUN;
      RUN:     if (run_tc) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    if (accept) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_step  = acc_q;
    mul_upper = acc_q[AccW-1:NBits];
    sh        = acc_q << 1;
    trial     = {1'b0, sh[AccW-1:NBits]} - {2'b00, b_mag_q};
    if (mode_q == MODE_MUL) begin
      if (acc_q[0]) mul_upper = mul_upper + {1'b0, a_mag_q};
      acc_step = {mul_upper, acc_q[NBits-1:0]} >> 1;
    end else if (!trial[NBits+1]) begin
      acc_step = {trial[NBits:0], sh[NBits-1:1], 1'b1};
    end else begin
      acc_step = sh;
    end
  end

  always_comb begin
    fix_result = '0;
    fix_sign   = 1'b0;
    fix_dz     = 1'b0;
    fix_ovf    = 1'b0;
    quo_s      = '0;
    rem_s      = '0;
    if (mode_q == MODE_MUL) begin
      fix_sign   = (a_sign_q ^ b_sign_q) && (acc_q[2*NBits-1:0] != '0);
      fix_result = fix_sign ? -acc_q[2*NBits-1:0] : acc_q[2*NBits-1:0];
    end else if (b_mag_q == '0) begin
      fix_dz     = 1'b1;
      fix_sign   = 1'b1;
      fix_result = {a_raw_q, {NBits{1'b1}}};
    end else if (a_sign_q && b_sign_q && a_mag_q == MinMag && b_mag_q == NBits'(1)) begin
      fix_ovf    = 1'b1;
      fix_sign   = 1'b1;
      fix_result = {{NBits{1'b0}}, MinMag};
    end else begin
      fix_sign   = (a_sign_q ^ b_sign_q) && (acc_q[NBits-1:0] != '0);
      quo_s      = fix_sign ? -acc_q[NBits-1:0] : acc_q[NBits-1:0];
      rem_s      = a_sign_q ? -acc_q[2*NBits-1:NBits] : acc_q[2*NBits-1:NBits];
      fix_result = {rem_s, quo_s};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: all datapath registers reset so an aborted operation leaves nothing visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= MODE_MUL;
      a_raw_q    <= '0;
      b_raw_q    <= '0;
      a_sign_q   <= 1'b0;
      b_sign_q   <= 1'b0;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      sign_q     <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (accept) begin
        mode_q  <= muldiv_mode_t'(mode);
        a_raw_q <= op_a;
        b_raw_q <= op_b;
      end
      unique case (state_q)
        LOAD: begin
          a_sign_q <= a_raw_q[NBits-1];
          b_sign_q <= b_raw_q[NBits-1];
          a_mag_q  <= a_mag_w;
          b_mag_q  <= b_mag_w;
          acc_q    <= {{(NBits+1){1'b0}}, (mode_q == MODE_MUL) ? b_mag_w : a_mag_w};
        end
        RUN: acc_q <= acc_step;
        FIX: begin
          result_q   <= fix_result;
          sign_q     <= fix_sign;
          div_zero_q <= fix_dz;
          ovf_q      <= fix_ovf;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q == LOAD) || (state_q == RUN) || (state_q == FIX);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign sign     = sign_q;
  assign div_zero = div_zero_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Self-checking bench for seq_muldiv_unit at NBits=8: directed vector table,
// multi-cycle corner sequences, and random operations against an arithmetic model.
module tb_seq_muldiv_unit;

  localparam int NB = 8;
  localparam int LATENCY = NB + 3;  // edges counted with the start-sampling edge as 1

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic signed [NB-1:0] op_a = '0, op_b = '0;
  logic busy, done, sign, div_zero, ovf;
  logic [2*NB-1:0] result;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;

  seq_muldiv_unit #(.NBits(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .sign(sign), .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              m;
    logic signed [NB-1:0] a, b;
    logic [2*NB-1:0] res;
    bit              s, dz, ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic; returns {ovf, div_zero, sign, result}.
  function automatic logic [2*NB+2:0] model(input bit m, input int a, input int b);
    int p, q, r;
    logic [2*NB-1:0] res;
    bit s, dz, ov;
    dz = 0; ov = 0;
    if (!m) begin
      p = a * b;
      res = p[2*NB-1:0];
      s = (p < 0);
    end else if (b == 0) begin
      res = {a[NB-1:0], {NB{1'b1}}};
      s = 1; dz = 1;
    end else if (a == -(1 << (NB-1)) && b == -1) begin
      res = 16'h0080;
      s = 1; ov = 1;
    end else begin
      q = a / b;
      r = a % b;
      res = {r[NB-1:0], q[NB-1:0]};
      s = (q < 0);
    end
    return {ov, dz, s, res};
  endfunction

  task automatic launch(input bit m, input logic signed [NB-1:0] a, input logic signed [NB-1:0] b);
    @(negedge clk);
    start = 1'b1; mode = m; op_a = a; op_b = b;
    @(posedge clk);
    cycles = 1;
    #1;
    start = 1'b0;
    op_a = NB'($urandom);
    op_b = NB'($urandom);
    mode = ~m;
    check("busy_after_start", {done, busy}, 2'b01);
  endtask

  task automatic wait_done();
    while (!done && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic check_outputs(input string tag, input logic [2*NB+2:0] exp);
    check({tag, "_result"}, result, exp[2*NB-1:0]);
    check({tag, "_sign"}, sign, exp[2*NB]);
    check({tag, "_div_zero"}, div_zero, exp[2*NB+1]);
    check({tag, "_ovf"}, ovf, exp[2*NB+2]);
  endtask

  vec_t vecs[12];
  logic signed [NB-1:0] ra, rb;
  bit rm;

  initial begin
    vecs[0]  = '{1'b0, -8'sd7,   8'sd13,  16'hFFA5, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'sh80,   8'sh80,  16'h4000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'sd0,    -8'sd5,  16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, -8'sd100, 8'sd7,   16'hFEF2, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'sd50,   8'sd0,   16'h32FF, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'sd9,    8'sd3,   16'h0003, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'sh80,   -8'sd1,  16'h0080, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 8'sd7,    -8'sd2,  16'h01FD, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'sd127,  -8'sd1,  16'hFF81, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'sd3,    8'sd5,   16'h0300, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, -8'sd3,   8'sd5,   16'hFD00, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'sh80,   8'sd1,   16'h0080, 1'b1, 1'b0, 1'b0};

    #12;
    check("reset_outputs", {busy, done, sign, div_zero, ovf, result}, '0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      launch(vecs[i].m, vecs[i].a, vecs[i].b);
      wait_done();
      check($sformatf("vec%0d_latency", i), cycles, LATENCY);
      check_outputs($sformatf("vec%0d", i), {vecs[i].ov, vecs[i].dz, vecs[i].s, vecs[i].res});
    end

    // Flags and result hold through LOAD/RUN until the next FIX.
    launch(1'b1, 8'sd50, 8'sd0);
    wait_done();
    launch(1'b1, 8'sd9, 8'sd3);
    repeat (5) begin @(posedge clk); #1; cycles++; end
    check("hold_result_mid_run", result, 16'h32FF);
    check("hold_div_zero_mid_run", div_zero, 1'b1);
    wait_done();
    check_outputs("after_dz", {1'b0, 1'b0, 1'b0, 16'h0003});

    // Start pulse and operand change while busy are ignored; done then holds.
    launch(1'b0, 8'sd25, -8'sd3);
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; op_a = 8'sd99; op_b = 8'sd2;
    @(negedge clk);
    start = 1'b0;
    cycles = 6;
    wait_done();
    check_outputs("busy_start", {1'b0, 1'b0, 1'b1, 16'hFFB5});
    repeat (3) @(posedge clk);
    #1;
    check("done_held", {done, busy, result}, {1'b1, 1'b0, 16'hFFB5});

    // Asynchronous reset in the middle of RUN.
    launch(1'b1, -8'sd100, 8'sd7);
    repeat (5) @(posedge clk);
    #2;
    check("busy_before_reset", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, sign, div_zero, ovf, result}, '0);
    @(negedge clk);
    @(negedge clk);
    check("reset_stays_idle", {busy, done}, 2'b00);
    rst = 1'b1;
    launch(1'b0, -8'sd7, 8'sd13);
    wait_done();
    check("post_reset_latency", cycles, LATENCY);
    check_outputs("post_reset", {1'b0, 1'b0, 1'b1, 16'hFFA5});

    for (int i = 0; i < 60; i++) begin
      rm = 1'($urandom);
      ra = NB'($urandom);
      rb = NB'($urandom);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 9) == 0) ra = 8'sh80;
      if ($urandom_range(0, 9) == 0) rb = -8'sd1;
      launch(rm, ra, rb);
      wait_done();
      check($sformatf("rand%0d_latency", i), cycles, LATENCY);
      check_outputs($sformatf("rand%0d", i), model(rm, int'(ra), int'(rb)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
